// File: rtl/issue_pair_sched.sv
// issue_pair_sched
// Dual-issue pairing scheduler for a two-wide in-order ID stage. Decides,
// each cycle, whether the two ID slots issue together, are split over two
// cycles, are held for a load-use hazard, or are flushed after a redirect.
//
// Ports
//   clk                     single clock, rising edge
//   rst                     asynchronous, active-low reset
//   valid1/valid2           ID slot holds a real instruction
//   rs1/rt1/rs2/rt2         ID source register numbers
//   destReg1                slot-1 destination register
//   RegWriteEn1             slot-1 writes destReg1
//   useRt1/useRt2           slot reads its rt operand
//   mem1/mem2               slot is a load or store
//   DestReg1_EX/DestReg2_EX EX-stage destinations
//   MemReadEn1_EX/2_EX      EX-stage instruction is a load
//   correct_en/jr_redirect  redirect requests (mispredict / jr)
//   issue1/issue2           slot issues this cycle
//   hold                    keep IF/ID contents (stall the front end)
//   flush_IFID/flush_IDEX   bubble the respective pipeline register
//   split_active            scheduler is in SPLIT
//   stall_cnt/split_cnt     saturating performance counters
//
// state   | meaning
// --------+---------------------------------------------------------------
// PAIR    | normal operation, both slots considered for issue together
// SPLIT   | slot 1 already issued, slot 2 waits for its own cycle
// RECOVER | post-redirect bubbles, counted down by rcnt
module issue_pair_sched #(
    parameter int RECOVER_CYCLES = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid1,
    input  logic             valid2,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rt1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rt2,
    input  logic [4:0]       destReg1,
    input  logic             RegWriteEn1,
    input  logic             useRt1,
    input  logic             useRt2,
    input  logic             mem1,
    input  logic             mem2,
    input  logic [4:0]       DestReg1_EX,
    input  logic [4:0]       DestReg2_EX,
    input  logic             MemReadEn1_EX,
    input  logic             MemReadEn2_EX,
    input  logic             correct_en,
    input  logic             jr_redirect,
    output logic             issue1,
    output logic             issue2,
    output logic             hold,
    output logic             flush_IFID,
    output logic             flush_IDEX,
    output logic             split_active,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] split_cnt
);

    typedef enum logic [1:0] {
        PAIR    = 2'd0,
        SPLIT   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam logic [3:0] RCNT_LOAD = 4'(RECOVER_CYCLES);

    state_t     state, state_nxt;
    logic [3:0] rcnt, rcnt_nxt;
    logic       split_inc;
    logic       lu1, lu2, conflict, redirect;

    // True when an EX-stage load writes a register this ID slot reads.
    // Register 0 is hardwired and never forms a dependency.
    function automatic logic ex_load_hit(
        input logic       mre,
        input logic [4:0] dex,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       use_rt
    );
        return mre && (dex != 5'd0) && ((rs == dex) || (use_rt && (rt == dex)));
    endfunction

    assign lu1 = valid1 &&
                 (ex_load_hit(MemReadEn1_EX, DestReg1_EX, rs1, rt1, useRt1) ||
                  ex_load_hit(MemReadEn2_EX, DestReg2_EX, rs1, rt1, useRt1));
    assign lu2 = valid2 &&
                 (ex_load_hit(MemReadEn1_EX, DestReg1_EX, rs2, rt2, useRt2) ||
                  ex_load_hit(MemReadEn2_EX, DestReg2_EX, rs2, rt2, useRt2));

    // Intra-pair RAW on slot-1's destination, or two memory ops competing
    // for the single memory port.
    assign conflict = valid1 && valid2 &&
                      ((RegWriteEn1 && (destReg1 != 5'd0) &&
                        ((rs2 == destReg1) || (useRt2 && (rt2 == destReg1)))) ||
                       (mem1 && mem2));

    assign redirect     = correct_en || jr_redirect;
    assign split_active = (state == SPLIT);

    always_comb begin
        issue1     = 1'b0;
        issue2     = 1'b0;
        hold       = 1'b0;
        flush_IFID = 1'b0;
        flush_IDEX = 1'b0;
        split_inc  = 1'b0;
        state_nxt  = state;
        rcnt_nxt   = rcnt;
        // Outputs are combinational, so they are gated while reset is held
        // to keep the pipeline quiet regardless of what ID presents.
        if (rst) begin
            if (redirect) begin
                flush_IFID = 1'b1;
                flush_IDEX = 1'b1;
                state_nxt  = RECOVER;
                rcnt_nxt   = RCNT_LOAD;
            end else begin
                case (state)
                    PAIR: begin
                        if (lu1 || lu2) begin
                            hold       = 1'b1;
                            flush_IDEX = 1'b1;
                        end else if (conflict) begin
                            issue1    = 1'b1;
                            hold      = 1'b1;
                            split_inc = 1'b1;
                            state_nxt = SPLIT;
                        end else begin
                            issue1 = valid1;
                            issue2 = valid2;
                        end
                    end
                    SPLIT: begin
                        if (lu2) begin
                            hold       = 1'b1;
                            flush_IDEX = 1'b1;
                        end else begin
                            issue2    = valid2;
                            state_nxt = PAIR;
                        end
                    end
                    RECOVER: begin
                        flush_IDEX = 1'b1;
                        rcnt_nxt   = (rcnt != 4'd0) ? rcnt - 4'd1 : 4'd0;
                        // <= 1 also recovers cleanly if rcnt is ever 0
                        if (rcnt <= 4'd1) begin
                            state_nxt = PAIR;
                        end
                    end
                    default: begin
                        state_nxt = PAIR;
                        rcnt_nxt  = 4'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= PAIR;
            rcnt      <= 4'd0;
            stall_cnt <= '0;
            split_cnt <= '0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
            if (hold && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (split_inc && (split_cnt != '1)) begin
                split_cnt <= split_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_issue_pair_sched.sv
module tb_issue_pair_sched;

    localparam int CW = 4;
    localparam int RC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid1, valid2;
    logic [4:0]    rs1, rt1, rs2, rt2, destReg1;
    logic          RegWriteEn1, useRt1, useRt2, mem1, mem2;
    logic [4:0]    DestReg1_EX, DestReg2_EX;
    logic          MemReadEn1_EX, MemReadEn2_EX;
    logic          correct_en, jr_redirect;
    logic          issue1, issue2, hold, flush_IFID, flush_IDEX, split_active;
    logic [CW-1:0] stall_cnt, split_cnt;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_split = 0;

    always #5 clk = ~clk;

    issue_pair_sched #(.RECOVER_CYCLES(RC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .valid1(valid1), .valid2(valid2),
        .rs1(rs1), .rt1(rt1), .rs2(rs2), .rt2(rt2), .destReg1(destReg1),
        .RegWriteEn1(RegWriteEn1), .useRt1(useRt1), .useRt2(useRt2),
        .mem1(mem1), .mem2(mem2),
        .DestReg1_EX(DestReg1_EX), .DestReg2_EX(DestReg2_EX),
        .MemReadEn1_EX(MemReadEn1_EX), .MemReadEn2_EX(MemReadEn2_EX),
        .correct_en(correct_en), .jr_redirect(jr_redirect),
        .issue1(issue1), .issue2(issue2), .hold(hold),
        .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
        .split_active(split_active),
        .stall_cnt(stall_cnt), .split_cnt(split_cnt)
    );

    typedef struct {
        logic       v1, v2;
        logic [4:0] rs1, rt1, rs2, rt2, d1;
        logic       we1, urt1, urt2, m1, m2;
        logic [4:0] dex1, dex2;
        logic       mre1, mre2;
        logic       e_i1, e_i2, e_hold, e_fidex, e_split;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic i1, input logic i2,
                           input logic h, input logic fif, input logic fid);
        chk({tag, ".issue1"}, int'(issue1), int'(i1));
        chk({tag, ".issue2"}, int'(issue2), int'(i2));
        chk({tag, ".hold"}, int'(hold), int'(h));
        chk({tag, ".flush_IFID"}, int'(flush_IFID), int'(fif));
        chk({tag, ".flush_IDEX"}, int'(flush_IDEX), int'(fid));
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, ".stall_cnt"}, int'(stall_cnt), exp_stall);
        chk({tag, ".split_cnt"}, int'(split_cnt), exp_split);
    endtask

    task automatic apply(input vec_t v);
        valid1 = v.v1; valid2 = v.v2;
        rs1 = v.rs1; rt1 = v.rt1; rs2 = v.rs2; rt2 = v.rt2; destReg1 = v.d1;
        RegWriteEn1 = v.we1; useRt1 = v.urt1; useRt2 = v.urt2;
        mem1 = v.m1; mem2 = v.m2;
        DestReg1_EX = v.dex1; DestReg2_EX = v.dex2;
        MemReadEn1_EX = v.mre1; MemReadEn2_EX = v.mre2;
    endtask

    // One clock; the bench's counter model follows what the cycle should do.
    task automatic tick(input logic h, input logic s);
        @(posedge clk);
        if (h && exp_stall < (1 << CW) - 1) exp_stall++;
        if (s && exp_split < (1 << CW) - 1) exp_split++;
        #1;
    endtask

    initial begin
        //         v1 v2 rs1 rt1 rs2 rt2 d1 we u1 u2 m1 m2 dx1 dx2 mr1 mr2 | i1 i2 h fid split
        vecs[0]  = '{1,1, 1,2,3,4,5, 1,1,1,0,0, 0,0,0,0, 1,1,0,0,0}; // independent
        vecs[1]  = '{1,1, 1,2,5,4,5, 1,1,1,0,0, 0,0,0,0, 1,0,1,0,1}; // RAW on rs2
        vecs[2]  = '{1,1, 1,2,3,5,5, 1,1,1,0,0, 0,0,0,0, 1,0,1,0,1}; // RAW on rt2
        vecs[3]  = '{1,1, 1,2,3,5,5, 1,1,0,0,0, 0,0,0,0, 1,1,0,0,0}; // rt2 unused
        vecs[4]  = '{1,1, 1,2,0,4,0, 1,1,1,0,0, 0,0,0,0, 1,1,0,0,0}; // r0 dest
        vecs[5]  = '{1,1, 1,2,5,4,5, 0,1,1,0,0, 0,0,0,0, 1,1,0,0,0}; // no write
        vecs[6]  = '{1,1, 1,2,3,4,0, 1,1,1,1,1, 0,0,0,0, 1,0,1,0,1}; // two mem ops
        vecs[7]  = '{1,0, 1,2,5,4,5, 1,1,1,0,0, 0,0,0,0, 1,0,0,0,0}; // slot2 empty
        vecs[8]  = '{0,1, 1,2,5,4,5, 1,1,1,0,0, 0,0,0,0, 0,1,0,0,0}; // slot1 empty
        vecs[9]  = '{1,1, 7,2,3,4,5, 1,1,1,0,0, 7,0,1,0, 0,0,1,1,0}; // load-use s1
        vecs[10] = '{1,1, 1,2,3,4,5, 1,1,1,0,0, 0,4,0,1, 0,0,1,1,0}; // load-use s2 rt
        vecs[11] = '{1,1, 0,2,3,4,5, 1,1,1,0,0, 0,0,1,0, 1,1,0,0,0}; // load to r0
        vecs[12] = '{1,1, 7,2,3,4,5, 1,1,1,0,0, 7,0,0,0, 1,1,0,0,0}; // EX not a load
        vecs[13] = '{0,1, 7,2,3,4,5, 1,1,1,0,0, 7,0,1,0, 0,1,0,0,0}; // hazard on empty s1
        vecs[14] = '{1,1, 1,7,3,4,5, 1,0,1,0,0, 7,0,1,0, 1,1,0,0,0}; // rt1 unused
        vecs[15] = '{1,1, 1,2,3,4,5, 1,1,1,1,0, 0,0,0,0, 1,1,0,0,0}; // one mem op
        vecs[16] = '{1,1, 1,2,3,4,5, 1,1,1,0,0, 0,1,0,1, 0,0,1,1,0}; // EX2 load -> s1
        vecs[17] = '{1,0, 1,2,3,4,5, 1,1,1,0,0, 0,4,0,1, 1,0,0,0,0}; // hazard on empty s2

        correct_en = 1'b1; jr_redirect = 1'b0;
        apply(vecs[1]);
        rst = 1'b0;
        #1;
        chk_out("reset", 0, 0, 0, 0, 0);
        chk("reset.split_active", int'(split_active), 0);
        chk_cnt("reset");
        repeat (2) @(posedge clk);
        #1;
        correct_en = 1'b0;
        rst = 1'b1;

        // Table: every vector starts from PAIR.
        for (int i = 0; i < 18; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            apply(vecs[i]);
            #1;
            chk_out(tag, vecs[i].e_i1, vecs[i].e_i2, vecs[i].e_hold, 0, vecs[i].e_fidex);
            tick(vecs[i].e_hold, vecs[i].e_split);
            chk({tag, ".split_active"}, int'(split_active), int'(vecs[i].e_split));
            if (vecs[i].e_split) begin
                chk_out({tag, ".second"}, 0, 1, 0, 0, 0);
                tick(0, 0);
                chk({tag, ".back_to_pair"}, int'(split_active), 0);
            end
            chk_cnt(tag);
        end

        // SPLIT stalled by a load-use on slot 2.
        apply(vecs[1]);
        #1;
        tick(1, 1);
        DestReg2_EX = 5'd5; MemReadEn2_EX = 1'b1;
        #1;
        chk("splitlu.split_active", int'(split_active), 1);
        chk_out("splitlu.stall", 0, 0, 1, 0, 1);
        tick(1, 0);
        chk("splitlu.still_split", int'(split_active), 1);
        MemReadEn2_EX = 1'b0;
        #1;
        chk_out("splitlu.release", 0, 1, 0, 0, 0);
        tick(0, 0);
        chk("splitlu.pair", int'(split_active), 0);
        chk_cnt("splitlu");

        // Mispredict while in SPLIT, two recovery cycles.
        apply(vecs[1]);
        #1;
        tick(1, 1);
        correct_en = 1'b1;
        #1;
        chk_out("redir.cycle", 0, 0, 0, 1, 1);
        tick(0, 0);
        correct_en = 1'b0;
        apply(vecs[0]);
        #1;
        chk("redir.rec1.split_active", int'(split_active), 0);
        chk_out("redir.rec1", 0, 0, 0, 0, 1);
        tick(0, 0);
        chk_out("redir.rec2", 0, 0, 0, 0, 1);
        tick(0, 0);
        chk_out("redir.pair", 1, 1, 0, 0, 0);
        chk_cnt("redir");

        // jr redirect during RECOVER reloads the counter.
        jr_redirect = 1'b1;
        #1;
        chk_out("reload.cycle", 0, 0, 0, 1, 1);
        tick(0, 0);
        jr_redirect = 1'b0;
        #1;
        chk_out("reload.rec1", 0, 0, 0, 0, 1);
        tick(0, 0);
        jr_redirect = 1'b1;
        #1;
        chk_out("reload.again", 0, 0, 0, 1, 1);
        tick(0, 0);
        jr_redirect = 1'b0;
        #1;
        chk_out("reload.rec_a", 0, 0, 0, 0, 1);
        tick(0, 0);
        chk_out("reload.rec_b", 0, 0, 0, 0, 1);
        tick(0, 0);
        chk_out("reload.pair", 1, 1, 0, 0, 0);

        // Counter saturation at 4 bits.
        apply(vecs[9]);
        repeat (20) tick(1, 0);
        chk("sat.stall_cnt", int'(stall_cnt), 15);
        for (int k = 0; k < 16; k++) begin
            apply(vecs[6]);
            #1;
            tick(1, 1);
            tick(0, 0);
        end
        chk("sat.split_cnt", int'(split_cnt), 15);
        chk("sat.stall_cnt_after", int'(stall_cnt), 15);

        // Reset in the middle of RECOVER.
        apply(vecs[0]);
        correct_en = 1'b1;
        #1;
        tick(0, 0);
        correct_en = 1'b0;
        #1;
        chk_out("rstrec.in_recover", 0, 0, 0, 0, 1);
        rst = 1'b0;
        #1;
        exp_stall = 0;
        exp_split = 0;
        chk_out("rstrec.held", 0, 0, 0, 0, 0);
        chk_cnt("rstrec.held");
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_out("rstrec.release", 1, 1, 0, 0, 0);
        tick(0, 0);
        chk_cnt("rstrec.after");

        // Reset in the middle of SPLIT.
        apply(vecs[1]);
        #1;
        tick(1, 1);
        chk("rstsplit.in_split", int'(split_active), 1);
        rst = 1'b0;
        #1;
        exp_stall = 0;
        exp_split = 0;
        chk("rstsplit.split_active", int'(split_active), 0);
        chk_out("rstsplit.held", 0, 0, 0, 0, 0);
        rst = 1'b1;
        apply(vecs[0]);
        #1;
        chk_out("rstsplit.release", 1, 1, 0, 0, 0);
        chk_cnt("rstsplit");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_pair_sched.md
ISSUE_PAIR_SCHED -- requirements
Module: issue_pair_sched

Interface
REQ-001 SHALL have parameter RECOVER_CYCLES, default 1, meaning cycles spent in RECOVER after a redirect (legal range 1-15).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the performance counters.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports valid1, valid2, input, 1 each: the ID slot holds a real instruction.
REQ-006 SHALL have ports rs1, rt1, rs2, rt2, destReg1, input, 5 each: ID source and destination register numbers.
REQ-007 SHALL have ports RegWriteEn1, useRt1, useRt2, mem1, mem2, input, 1 each: slot-1 writes a register; slot reads rt; slot is a load or store.
REQ-008 SHALL have ports DestReg1_EX, DestReg2_EX, input, 5 each; MemReadEn1_EX, MemReadEn2_EX, input, 1 each: EX-stage load destinations.
REQ-009 SHALL have ports correct_en, jr_redirect, input, 1 each: branch-mispredict and jr redirect requests.
REQ-010 SHALL have ports issue1, issue2, hold, flush_IFID, flush_IDEX, output, 1 each.
REQ-011 SHALL have ports split_active, output, 1 (state is SPLIT), and stall_cnt, split_cnt, output, CNT_W each.

Function
REQ-012 SHALL implement a three-state FSM: PAIR, SPLIT, RECOVER; issue/hold/flush outputs are combinational from state and inputs; counters are registered.
REQ-013 SHALL compute lu(s) = valid_s and, for x in {1,2}, MemReadEn_x_EX and DestReg_x_EX != 0 and (rs_s == DestReg_x_EX or (useRt_s and rt_s == DestReg_x_EX)).
REQ-014 SHALL compute conflict = valid1 and valid2 and ((RegWriteEn1 and destReg1 != 0 and (rs2 == destReg1 or (useRt2 and rt2 == destReg1))) or (mem1 and mem2)).
REQ-015 Redirect (correct_en or jr_redirect) in any state SHALL take priority: flush_IFID=1, flush_IDEX=1, issue1=issue2=0, hold=0; next state RECOVER with counter loaded to RECOVER_CYCLES.
REQ-016 PAIR, lu(1) or lu(2): issue1=issue2=0, hold=1, flush_IDEX=1; stay PAIR.
REQ-017 PAIR, else conflict: issue1=1, issue2=0, hold=1; next SPLIT; split_cnt increments.
REQ-018 PAIR, else: issue1=valid1, issue2=valid2, hold=0; stay PAIR.
REQ-019 SPLIT, lu(2): issue2=0, hold=1, flush_IDEX=1; stay SPLIT.
REQ-020 SPLIT, else: issue1=0, issue2=1, hold=0; next PAIR.
REQ-021 RECOVER: flush_IDEX=1, issue1=issue2=0, hold=0; counter decrements each cycle; at counter==1, next state PAIR.
REQ-022 Redirect during RECOVER SHALL reload the counter to RECOVER_CYCLES.
REQ-023 stall_cnt SHALL increment in every cycle with hold=1, saturating at all-ones; split_cnt SHALL saturate likewise.
REQ-024 Register 0 SHALL never create a hazard or conflict.
REQ-025 An invalid slot SHALL never issue, never create a hazard and never create a conflict.

Reset
REQ-026 While rst=0: state PAIR, recover counter 0, stall_cnt=split_cnt=0, all 1-bit outputs 0.
REQ-027 Reset asserted mid-SPLIT or mid-RECOVER SHALL abandon the sequence immediately; the first cycle after release behaves as PAIR.

Verification
REQ-028 Independent pair (rs2=3, rt2=4, destReg1=5, no loads in EX) -> issue1=issue2=1, hold=0, counters unchanged.
REQ-029 destReg1=5, RegWriteEn1=1, rs2=5 -> cycle N: issue1=1, issue2=0, hold=1; cycle N+1: split_active=1, issue2=1, hold=0; split_cnt=1.
REQ-030 MemReadEn1_EX=1, DestReg1_EX=7, rs1=7 -> issue1=issue2=0, hold=1, flush_IDEX=1; stall_cnt increments by 1.
REQ-031 correct_en pulse while in SPLIT with RECOVER_CYCLES=2 -> same cycle: flush_IFID=flush_IDEX=1; next 2 cycles: RECOVER with flush_IDEX=1; then PAIR.
REQ-032 Both slots are loads (mem1=mem2=1) with destReg1=0 -> split occurs; with CNT_W=4, 16 forced stalls -> stall_cnt holds at 15.
REQ-033 rst driven low during RECOVER -> outputs 0 immediately, counters 0; after release, an independent pair dual-issues.
